// File: rtl/avalon_port_arbiter_if.sv
// avalon_port_arbiter_if: I/D request ports and single-master bus shared through the arbiter
interface avalon_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic [ADDR_W-1:0] addr_i;
  logic              done_i;
  logic [WIDTH-1:0]  rdata_i;
  logic              req_d;
  logic              rnw_d;
  logic [ADDR_W-1:0] addr_d;
  logic [WIDTH-1:0]  wdata_d;
  logic              done_d;
  logic [WIDTH-1:0]  rdata_d;
  logic              m_start;
  logic              m_rnw;
  logic [ADDR_W-1:0] m_address;
  logic [WIDTH-1:0]  m_wdata;
  logic              m_done;
  logic [WIDTH-1:0]  m_rdata;
  logic              busy;
  logic              owner;
  modport slave (
    input  req_i, addr_i, req_d, rnw_d, addr_d, wdata_d, m_done, m_rdata,
    output done_i, rdata_i, done_d, rdata_d, m_start, m_rnw, m_address, m_wdata, busy, owner
  );
  modport master (
    output req_i, addr_i, req_d, rnw_d, addr_d, wdata_d, m_done, m_rdata,
    input  done_i, rdata_i, done_d, rdata_d, m_start, m_rnw, m_address, m_wdata, busy, owner
  );
endinterface

// File: rtl/avalon_port_arbiter.sv
// avalon_port_arbiter: shares one avalon master between I and D ports; ARB_ROUND_ROBIN_EN selects round-robin over fixed D priority
module avalon_port_arbiter (
  input logic CLK,
  input logic RST,
  avalon_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  state_t state;
  logic   grant_d;
`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d = bus.req_d & (~bus.req_i | ~bus.owner);
`else
  assign grant_d = bus.req_d;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      bus.m_start   <= 1'b0;
      bus.done_i    <= 1'b0;
      bus.done_d    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.owner     <= 1'b0;
      bus.m_rnw     <= 1'b1;
      bus.m_address <= '0;
      bus.m_wdata   <= '0;
      bus.rdata_i   <= '0;
      bus.rdata_d   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_i | bus.req_d) begin
          bus.owner     <= grant_d;
          bus.m_rnw     <= grant_d ? bus.rnw_d : 1'b1;
          bus.m_address <= grant_d ? bus.addr_d : bus.addr_i;
          bus.m_wdata   <= grant_d ? bus.wdata_d : '0;
          bus.m_start   <= 1'b1;
          bus.busy      <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: begin
          bus.m_start <= 1'b0;
          state       <= BUSY;
        end
        BUSY: if (bus.m_done) begin
          if (bus.owner) bus.rdata_d <= bus.m_rdata;
          else bus.rdata_i <= bus.m_rdata;
          bus.done_d <= bus.owner;
          bus.done_i <= ~bus.owner;
          state      <= RESP;
        end
        RESP: begin
          bus.done_i <= 1'b0;
          bus.done_d <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
